// File: rtl/delta_forward.sv
// Encoder delta stage: gathers BLOCK_SIZE signed words, emits base + bit-transposed first differences.
// Optional partial-block close via flush_i when DELTA_FWD_FLUSH_EN is defined.
package ebpc_pkg;
  parameter int DATA_W     = 8;
  parameter int BLOCK_SIZE = 8;

  typedef struct packed {
    logic [DATA_W-1:0]               base;
    logic [DATA_W:0][BLOCK_SIZE-2:0] dbp;
  } dbp_block_t;
endpackage

module delta_forward
  import ebpc_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     vld_i,
  output logic                     rdy_o,
  output dbp_block_t               data_o,
  output logic                     vld_o,
  input  logic                     rdy_i,
  input  logic                     clr_i,
  input  logic                     flush_i
);
  localparam int NDIFF = BLOCK_SIZE - 1;
  localparam int IDX_W = $clog2(BLOCK_SIZE);

  typedef enum logic {FILL, OUT} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W:0]   diff_q [NDIFF];
  logic [DATA_W:0]   diff_d [NDIFF];
  logic [DATA_W:0]   delta;
  logic              accept;
  logic              last_word;
  logic              flush_req;

`ifdef DELTA_FWD_FLUSH_EN
  assign flush_req = flush_i;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush_req    = 1'b0;
`endif

  // One extra bit makes the signed difference exact for any pair of words.
  assign delta     = {data_i[DATA_W-1], data_i} - {prev_q[DATA_W-1], prev_q};
  assign accept    = vld_i & rdy_o;
  assign last_word = (idx_q == IDX_W'(BLOCK_SIZE - 1));

  always_comb begin
    vld_o       = (state_q == OUT);
    rdy_o       = (state_q == FILL) ? 1'b1 : rdy_i;
    data_o.base = base_q;
    data_o.dbp  = '0;
    for (int i = 0; i < NDIFF; i++) begin
      for (int j = 0; j <= DATA_W; j++) begin
        data_o.dbp[j][NDIFF-1-i] = diff_q[i][j];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    prev_d  = prev_q;
    diff_d  = diff_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          prev_d = data_i;
          if (idx_q == '0) base_d = data_i;
          for (int i = 0; i < NDIFF; i++) begin
            if (IDX_W'(i + 1) == idx_q) diff_d[i] = delta;
          end
          if (last_word) begin
            idx_d   = '0;
            state_d = OUT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        // Padding with zero diffs is equivalent to repeating the last word.
        if (flush_req && (state_d == FILL) && (idx_d != '0)) begin
          for (int i = 0; i < NDIFF; i++) begin
            if ((i + 1) >= int'(idx_d)) diff_d[i] = '0;
          end
          idx_d   = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (rdy_i) begin
          state_d = FILL;
          if (vld_i) begin
            base_d = data_i;
            prev_d = data_i;
            idx_d  = IDX_W'(1);
          end else begin
            idx_d = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
    if (clr_i) begin
      state_d = FILL;
      idx_d   = '0;
      base_d  = '0;
      prev_d  = '0;
      for (int i = 0; i < NDIFF; i++) diff_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      idx_q   <= '0;
      base_q  <= '0;
      prev_q  <= '0;
      for (int i = 0; i < NDIFF; i++) diff_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      prev_q  <= prev_d;
      for (int i = 0; i < NDIFF; i++) diff_q[i] <= diff_d[i];
    end
  end

endmodule

// File: tb/tb_delta_forward.sv
// Bench for delta_forward: directed and random stimulus against a block-level queue model.
module tb_delta_forward;
  import ebpc_pkg::*;

  localparam int DW1 = DATA_W + 1;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic signed [DATA_W-1:0] data_i = '0;
  logic                     vld_i = 1'b0;
  logic                     rdy_o;
  dbp_block_t               data_o;
  logic                     vld_o;
  logic                     rdy_i = 1'b0;
  logic                     clr_i = 1'b0;
  logic                     flush_i = 1'b0;

  delta_forward dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .data_i (data_i),
    .vld_i  (vld_i),
    .rdy_o  (rdy_o),
    .data_o (data_o),
    .vld_o  (vld_o),
    .rdy_i  (rdy_i),
    .clr_i  (clr_i),
    .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  int         errors = 0;
  int         checks = 0;
  int         nblk   = 0;
  int         cur[$];
  dbp_block_t exp_q[$];

  function automatic dbp_block_t make_block(input int w[$]);
    dbp_block_t       b;
    logic [DW1-1:0]   d;
    b.base = DATA_W'(w[0]);
    b.dbp  = '0;
    for (int i = 0; i < BLOCK_SIZE - 1; i++) begin
      d = ((i + 1) < w.size()) ? DW1'(w[i+1] - w[i]) : '0;
      for (int j = 0; j < DW1; j++) b.dbp[j][BLOCK_SIZE-2-i] = d[j];
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled 2 units later.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic r,
                     input logic c = 1'b0, input logic f = 1'b0);
    logic exp_vld, exp_rdy, was_fill;
    vld_i = v; data_i = d; rdy_i = r; clr_i = c; flush_i = f;
    #2;
    exp_vld  = (exp_q.size() > 0);
    exp_rdy  = exp_vld ? r : 1'b1;
    was_fill = !exp_vld;
    check("vld_o", 128'(vld_o), 128'(exp_vld));
    check("rdy_o", 128'(rdy_o), 128'(exp_rdy));
    if (exp_vld) check("data_o", 128'(data_o), 128'(exp_q[0]));
    if (c) begin
      cur.delete();
      exp_q.delete();
    end else begin
      if (exp_vld && r) begin
        void'(exp_q.pop_front());
        nblk++;
      end
      if (v && exp_rdy) begin
        cur.push_back(int'($signed(d)));
        if (cur.size() == BLOCK_SIZE) begin
          exp_q.push_back(make_block(cur));
          cur.delete();
        end
      end
`ifdef DELTA_FWD_FLUSH_EN
      if (f && was_fill && cur.size() > 0) begin
        exp_q.push_back(make_block(cur));
        cur.delete();
      end
`else
      if (f && was_fill) begin
        // flush_i has no effect in this build
      end
`endif
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int             t1[8];
    logic [DW1-1:0] col;
    int             n0;
    logic [DATA_W-1:0] w;

    // Reset state
    #2;
    check("rst_vld_o", 128'(vld_o), 128'(0));
    check("rst_rdy_o", 128'(rdy_o), 128'(1));
    check("rst_data_o", 128'(data_o), 128'(0));
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc(0, 0, 1);

    // Directed stream with extreme values
    t1 = '{10, 12, 11, 11, -128, 127, 0, 5};
    for (int i = 0; i < 8; i++) cyc(1, DATA_W'(t1[i]), 1);
    check("t1_vld_after_8th", 128'(vld_o), 128'(1));
    check("t1_base", 128'(data_o.base), 128'(8'd10));
    check("t1_sign3", 128'(data_o.dbp[8][3]), 128'(1));
    for (int j = 0; j < DW1; j++) col[j] = data_o.dbp[j][3];
    check("t1_diff3", 128'(col), 128'(9'h175));
    for (int j = 0; j < DW1; j++) col[j] = data_o.dbp[j][2];
    check("t1_diff4", 128'(col), 128'(9'h0ff));
    for (int j = 0; j < DW1; j++) col[j] = data_o.dbp[j][6];
    check("t1_diff0", 128'(col), 128'(9'h002));
    cyc(0, 0, 1);

    // 32 random words back-to-back
    n0 = nblk;
    for (int i = 0; i < 32; i++) cyc(1, DATA_W'($urandom), 1);
    cyc(0, 0, 1);
    check("t2_blocks", 128'(nblk - n0), 128'(4));

    // Downstream stall with a pending word
    for (int i = 0; i < 8; i++) cyc(1, DATA_W'($urandom), 1);
    for (int i = 0; i < 5; i++) cyc(1, 8'h5a, 0);
    cyc(1, 8'h5a, 1);
    for (int i = 0; i < 7; i++) cyc(1, DATA_W'($urandom), 1);
    check("t3_base", 128'(data_o.base), 128'(8'h5a));
    cyc(0, 0, 1);

    // Clear mid-block, then a fresh block
    for (int i = 0; i < 4; i++) cyc(1, DATA_W'($urandom), 1);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cyc(1, DATA_W'(8'h30 + i * 3), 1);
    check("t4_base", 128'(data_o.base), 128'(8'h30));
    cyc(1, 8'h11, 1, 1);
    check("t4_clr_vld", 128'(vld_o), 128'(0));
    cyc(0, 0, 1);

`ifdef DELTA_FWD_FLUSH_EN
    // Partial block closed by flush
    cyc(1, 8'd7, 1);
    cyc(1, 8'd9, 1);
    cyc(1, 8'd4, 1);
    cyc(0, 0, 1, 0, 1);
    check("t5_vld", 128'(vld_o), 128'(1));
    check("t5_base", 128'(data_o.base), 128'(8'd7));
    for (int j = 0; j < DW1; j++) col[j] = data_o.dbp[j][5];
    check("t5_diff1", 128'(col), 128'(9'h1fb));
    cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, DATA_W'($urandom), 1);
    cyc(0, 0, 1);
`endif

    // Random mix of valid, ready, clear and flush
    for (int i = 0; i < 400; i++) begin
      w = DATA_W'($urandom);
      cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0);
    end

    // Reset in the middle of a block
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, DATA_W'($urandom), 1);
    rst_ni = 1'b0;
    #2;
    check("mid_rst_vld_o", 128'(vld_o), 128'(0));
    check("mid_rst_rdy_o", 128'(rdy_o), 128'(1));
    check("mid_rst_data_o", 128'(data_o), 128'(0));
    cur.delete();
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1, DATA_W'($urandom), 1);
    cyc(0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
